// File: rtl/mac_dot_sequencer_if.sv
// Handshake and data bundle between the dot-product sequencer, its command source,
// operand buffer, MAC lane and result consumer. master = sequencer side.
interface mac_dot_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_W-1:0]     cmd_len;
  logic [ADDR_W-1:0]    cmd_base;
  logic [WIDTH-1:0]     cmd_bias;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [WIDTH-1:0]     rd_a;
  logic [WIDTH-1:0]     rd_b;
  logic                 mac_start;
  logic [WIDTH-1:0]     mac_a;
  logic [WIDTH-1:0]     mac_b;
  logic [2*WIDTH-1:0]   mac_acc_in;
  logic [2*WIDTH-1:0]   mac_acc_out;
  logic                 mac_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_data;
  logic                 res_sat;
  logic                 res_err;

  modport master (
    input  cmd_valid, cmd_len, cmd_base, cmd_bias,
    output cmd_ready,
    output rd_en, rd_addr,
    input  rd_a, rd_b,
    output mac_start, mac_a, mac_b, mac_acc_in,
    input  mac_acc_out, mac_valid,
    output res_valid, res_data, res_sat, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_base, cmd_bias,
    input  cmd_ready,
    input  rd_en, rd_addr,
    output rd_a, rd_b,
    input  mac_start, mac_a, mac_b, mac_acc_in,
    output mac_acc_out, mac_valid,
    input  res_valid, res_data, res_sat, res_err,
    output res_ready
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences one MAC per element pair with a single MAC in flight, then saturates the Q21.10 sum to Q5.10.
// 6 cycles per element with a 4-stage MAC; command held off while busy, result held until res_ready.
module mac_dot_sequencer #(
  parameter int WIDTH   = 16,
  parameter int LEN_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  mac_dot_sequencer_if.master bus
);
  localparam int ACC_W = 2 * WIDTH;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     err_q, err_d;
  logic [WIDTH-1:0]         sat_data;
  logic                     sat_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      base_q <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      base_q <= base_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    len_d   = len_q;
    base_d  = base_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          acc_d   = ACC_W'($signed(bus.cmd_bias));
          idx_d   = '0;
          len_d   = bus.cmd_len;
          base_d  = bus.cmd_base;
          err_d   = 1'b0;
          state_d = (bus.cmd_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only one MAC is ever outstanding, so acc_out can go straight back as the next acc_in.
        if (bus.mac_valid) begin
          acc_d   = $signed(bus.mac_acc_out);
          idx_d   = idx_q + LEN_W'(1);
          state_d = (idx_q == len_q - LEN_W'(1)) ? S_DONE : S_FETCH;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sat_data = acc_q[WIDTH-1:0];
    sat_flag = 1'b0;
    if (acc_q > SAT_MAX) begin
      sat_data = SAT_MAX[WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      sat_data = SAT_MIN[WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    bus.cmd_ready  = (state_q == S_IDLE);
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.mac_start  = 1'b0;
    bus.mac_a      = '0;
    bus.mac_b      = '0;
    bus.mac_acc_in = '0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;
    bus.res_sat    = 1'b0;
    bus.res_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base_q + ADDR_W'(idx_q);
      end
      S_ISSUE: begin
        bus.mac_start  = 1'b1;
        bus.mac_a      = bus.rd_a;
        bus.mac_b      = bus.rd_b;
        bus.mac_acc_in = acc_q;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        bus.res_err   = err_q;
        bus.res_data  = err_q ? '0 : sat_data;
        bus.res_sat   = err_q ? 1'b0 : sat_flag;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: operand buffer model, 4-stage MAC stub, vector table plus reset sequences.
module tb_mac_dot_sequencer;
  localparam int WIDTH = 16, LEN_W = 8, ADDR_W = 8, TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  mac_dot_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Operand buffer with one cycle of read latency.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_a <= mem_a[bus.rd_addr];
      bus.rd_b <= mem_b[bus.rd_addr];
    end
  end

  // MAC stub: acc_out = acc_in + (a*b >>> 10), result valid four cycles after mac_start.
  logic               mac_en = 1'b1;
  logic               spur   = 1'b0;
  logic [3:0]         s_vld  = '0;
  logic signed [31:0] s_acc [4] = '{default: 0};
  always @(posedge clk) begin
    s_vld[0] <= bus.mac_start & mac_en;
    s_acc[0] <= $signed(bus.mac_acc_in) + ((32'($signed(bus.mac_a)) * 32'($signed(bus.mac_b))) >>> 10);
    for (int i = 1; i < 4; i++) begin
      s_vld[i] <= s_vld[i-1];
      s_acc[i] <= s_acc[i-1];
    end
  end
  assign bus.mac_valid   = s_vld[3] | spur;
  assign bus.mac_acc_out = s_acc[3];

  // Cumulative activity monitors, sampled on the falling edge.
  int          n_start = 0;
  int          n_rd    = 0;
  int          n_gate  = 0;
  logic [7:0]  addr_log [1024];
  always @(negedge clk) begin
    if (bus.mac_start) n_start <= n_start + 1;
    if (bus.rd_en) begin
      addr_log[n_rd % 1024] <= bus.rd_addr;
      n_rd <= n_rd + 1;
    end
    if (!bus.mac_start && ((bus.mac_a != 0) || (bus.mac_b != 0) || (bus.mac_acc_in != 0)))
      n_gate <= n_gate + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 32'({bus.cmd_ready, bus.rd_en, bus.mac_start, bus.res_valid, bus.res_sat, bus.res_err}),
        32'b100000);
    chk({tag, "_data"}, 32'({bus.res_data, bus.rd_addr}), 32'h0);
    chk({tag, "_mac"}, bus.mac_acc_in | 32'(bus.mac_a) | 32'(bus.mac_b), 32'h0);
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  base;
    logic [15:0] bias;
    logic [15:0] a [4];
    logic [15:0] b [4];
    bit          en;
    int          hold;
    logic [15:0] exp_data;
    bit          exp_sat;
    bit          exp_err;
    int          exp_starts;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t t, input int id);
    int          cyc;
    int          st0, rd0;
    bit          got, stable, addr_ok;
    logic [15:0] d0;
    for (int i = 0; i < 4; i++) begin
      mem_a[8'(t.base + i)] = t.a[i];
      mem_b[8'(t.base + i)] = t.b[i];
    end
    mac_en        = t.en;
    st0           = n_start;
    rd0           = n_rd;
    bus.cmd_len   = t.len;
    bus.cmd_base  = t.base;
    bus.cmd_bias  = t.bias;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 2;
    chk($sformatf("v%0d_busy_rdy", id), 32'(bus.cmd_ready), 32'h0);
    got = 1'b0;
    while (!got && cyc < 200) begin
      if (bus.res_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk($sformatf("v%0d_latency", id), 32'(cyc), 32'(t.exp_lat));
    chk($sformatf("v%0d_data", id), 32'(bus.res_data), 32'(t.exp_data));
    chk($sformatf("v%0d_sat_err", id), 32'({bus.res_sat, bus.res_err}), 32'({t.exp_sat, t.exp_err}));
    if (t.hold > 0) begin
      stable = 1'b1;
      d0 = bus.res_data;
      for (int h = 0; h < t.hold; h++) begin
        @(posedge clk); #1;
        if (!bus.res_valid || bus.res_data !== d0) stable = 1'b0;
      end
      chk($sformatf("v%0d_hold_stable", id), 32'(stable), 32'h1);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk($sformatf("v%0d_taken", id), 32'({bus.cmd_ready, bus.res_valid, bus.res_err}), 32'b100);
    chk($sformatf("v%0d_starts", id), 32'(n_start - st0), 32'(t.exp_starts));
    chk($sformatf("v%0d_reads", id), 32'(n_rd - rd0), 32'(t.exp_starts));
    if (t.exp_starts > 0) begin
      addr_ok = 1'b1;
      for (int i = 0; i < t.exp_starts; i++)
        if (addr_log[(rd0 + i) % 1024] !== 8'(t.base + i)) addr_ok = 1'b0;
      chk($sformatf("v%0d_addr_seq", id), 32'(addr_ok), 32'h1);
    end
  endtask

  vec_t v [9];

  initial begin
    int st0, wait_cyc;
    v[0] = '{8'd3, 8'h00, 16'h0000, '{16'h0400, 16'h0800, 16'h0200, 16'h0000},
             '{16'h0400, 16'h0800, 16'h0200, 16'h0000}, 1'b1, 0, 16'h1500, 1'b0, 1'b0, 3, 20};
    v[1] = '{8'd0, 8'h20, 16'hFC00, '{16'h0400, 16'h0400, 16'h0400, 16'h0400},
             '{16'h0400, 16'h0400, 16'h0400, 16'h0400}, 1'b1, 0, 16'hFC00, 1'b0, 1'b0, 0, 2};
    v[2] = '{8'd4, 8'h10, 16'h0000, '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00},
             '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00}, 1'b1, 0, 16'h7FFF, 1'b1, 1'b0, 4, 26};
    v[3] = '{8'd4, 8'h10, 16'h0000, '{16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00},
             '{16'h8400, 16'h8400, 16'h8400, 16'h8400}, 1'b1, 0, 16'h8000, 1'b1, 1'b0, 4, 26};
    v[4] = '{8'd2, 8'h30, 16'h0000, '{16'h0400, 16'h0400, 16'h0000, 16'h0000},
             '{16'h0400, 16'h0400, 16'h0000, 16'h0000}, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1, 19};
    v[5] = '{8'd2, 8'h40, 16'h0100, '{16'h0C00, 16'hFE00, 16'h0000, 16'h0000},
             '{16'h0400, 16'h0800, 16'h0000, 16'h0000}, 1'b1, 0, 16'h0900, 1'b0, 1'b0, 2, 14};
    v[6] = '{8'd4, 8'hFE, 16'h0000, '{16'h0400, 16'h0400, 16'h0400, 16'h0400},
             '{16'h0400, 16'h0800, 16'h0C00, 16'h1000}, 1'b1, 10, 16'h2800, 1'b0, 1'b0, 4, 26};
    v[7] = '{8'd1, 8'h50, 16'h0000, '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000},
             '{16'h0400, 16'h0000, 16'h0000, 16'h0000}, 1'b1, 0, 16'h7FFF, 1'b0, 1'b0, 1, 8};
    v[8] = '{8'd0, 8'h60, 16'h8000, '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
             '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b1, 0, 16'h8000, 1'b0, 1'b0, 0, 2};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_base  = '0;
    bus.cmd_bias  = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(v[i], i);

    // Reset during the second WAIT of an N=3 command.
    for (int i = 0; i < 4; i++) begin
      mem_a[8'(i)] = v[0].a[i];
      mem_b[8'(i)] = v[0].b[i];
    end
    mac_en        = 1'b1;
    st0           = n_start;
    bus.cmd_len   = 8'd3;
    bus.cmd_base  = 8'h00;
    bus.cmd_bias  = 16'h0000;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_cyc = 0;
    while (n_start - st0 < 2 && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("midrst_reached_2nd_issue", 32'(n_start - st0), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst_async");
    @(posedge clk); #1;
    chk_reset_outs("midrst_next");
    rst = 1'b0;
    st0 = n_start;
    repeat (3) @(posedge clk);
    #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_start_after", 32'(n_start - st0), 32'h0);
    chk("spur_ignored", 32'({bus.cmd_ready, bus.res_valid}), 32'b10);
    run_vec(v[0], 9);

    chk("mac_zero_when_idle", 32'(n_gate), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
